act_requant_pack: RTL and testbench
===================================

Name: act_requant_pack

Overview:
- Sits directly downstream of the 16-input neuron stage.
- Consumes the stream of signed 16-bit neuron results (one per valid cycle), requantizes each to signed 8-bit by arithmetic right shift with saturation, and packs N consecutive results into one activation vector.
- The vector drives the x0..x15 inputs of the next layer's neurons.
- Double-buffered (fill buffer plus output register) with valid/ready handshake, so that upstream can keep streaming while a vector is held.

Parameters:
- N, 16, lanes per output vector (2..16).
- CW, 5, width of fill_count; must satisfy 2^CW > N.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  16  signed neuron result.
- in_valid  in  1  in_data valid this cycle.
- in_ready  out  1  block can accept in_data this cycle.
- shift  in  4  requantization right-shift amount (0..15); sampled per accepted element.
- vec_data  out  8*N  packed int8 lanes; lane i at bits [8i+7:8i].
- vec_valid  out  1  vec_data holds a complete vector.
- vec_ready  in  1  downstream accepts vec_data this cycle.
- fill_count  out  CW  lanes written into the current fill buffer (0..N-1).

Behaviour:
- Reset (sync, active-high, overrides all): vec_valid=0, vec_data=0, fill_count=0, fill-buffer-full flag=0, so in_ready=1. A partial fill or held vector is discarded; no vector is emitted for pre-reset data.
- Accept: in_valid & in_ready. Transfer out: vec_valid & vec_ready.
- Requantize, combinational, per accepted element:
  - t = in_data >>> shift (arithmetic, sign-preserving).
  - q = 127 if t > 127; q = -128 if t < -128; else t[7:0].
  - Intermediate width is at least 17 bits signed.
- Fill:
  - On accept, q is written to fill lane fill_count and fill_count increments.
  - The accept that writes lane N-1 completes the vector, and fill_count wraps to 0.
- Completion when the output slot is free (vec_valid=0, or a transfer out in the same cycle):
  - The full vector, including the lane written this cycle, loads into vec_data.
  - vec_valid=1 on the next cycle, so latency is 1 cycle from the last accepted element to vec_valid.
- Completion when the output slot is occupied and not draining:
  - The fill buffer is marked full and in_ready=0.
  - On the first cycle with a transfer out, the fill buffer moves to vec_data; vec_valid stays 1 and the full flag clears, so in_ready=1 on the next cycle.
- in_ready = !fill_full. It is a function of registered state only; no combinational path from vec_ready.
- A transfer out with no pending vector sets vec_valid=0 on the next cycle. vec_data holds its last value; lanes are not cleared.
- vec_data and vec_valid are stable while vec_valid=1 and vec_ready=0.
- in_valid while in_ready=0: ignored, no state change; upstream must hold or drop, since the neuron stage has no stall.
- Throughput: one element per cycle indefinitely when vec_ready is held at 1.
- shift may change between elements; each lane uses the shift value present at its own accept.

Optional Feature:
- Macro: ACT_ROUND_EN.
- Defined: round-half-up before the shift. When shift>0, t = (in_data + 2^(shift-1)) >>> shift, computed in 17 bits so there is no overflow. When shift=0, there is no change. Saturation is then applied as above.
- Undefined: pure truncation (floor) via arithmetic shift. The rounding adder is not synthesized.

Test Plan:
- Basic pack: shift=0, vec_ready=1, feed 0..15 on consecutive cycles -> vec_valid high exactly 1 cycle after the 16th accept; lane i = i; fill_count returns to 0; in_ready stays 1.
- Saturation: shift=2 with in_data 1000 / -1000 / 400 / -6 -> lanes 127 / -128 / 100 / -2. Also shift=0 with 32767 -> 127 and -32768 -> -128.
- Rounding: shift=2 with in_data 6 / -6 / 5:
  - Without ACT_ROUND_EN -> 1 / -2 / 1.
  - With ACT_ROUND_EN -> 2 / -1 / 1.
- Backpressure: vec_ready=0, feed 32 elements (values k) -> first vector held stable; in_ready falls the cycle after the 32nd accept. Raise vec_ready -> first vector transfers, second vector (16..31) valid the next cycle, in_ready returns to 1.
- Simultaneous drain and complete: vector A held, vec_ready=1 in the same cycle as the 16th element of vector B -> vec_valid stays 1 with B on the next cycle; in_ready never drops.
- Reset mid-fill: accept 7 elements, pulse reset for 1 cycle, then feed 16 elements of value 3 -> exactly one vector, all lanes 3; vec_valid=0 and fill_count=0 the cycle after reset.

Source files
------------

// File: rtl/act_requant_pack.sv
// Requantizes signed 16-bit neuron results to int8 (shift + saturate) and packs N lanes per vector.
// Optional macro ACT_ROUND_EN adds round-half-up ahead of the shift; default build truncates.
module act_requant_pack #(
    parameter int unsigned N  = 16,
    parameter int unsigned CW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        shift,
    output logic [8*N-1:0]    vec_data,
    output logic              vec_valid,
    input  logic              vec_ready,
    output logic [CW-1:0]     fill_count
);

    localparam int unsigned LW = 8;
    localparam int unsigned VW = LW * N;

    logic [VW-1:0]      r_fill;
    logic [CW-1:0]      r_fill_count;
    logic               r_in_ready;
    logic [VW-1:0]      r_vec_data;
    logic               r_vec_valid;

    logic signed [16:0] w_ext;
    logic signed [16:0] w_sum;
    logic signed [16:0] w_t;
    logic [LW-1:0]      w_q;
    logic [VW-1:0]      w_fill_next;
    logic               w_accept;
    logic               w_xfer;
    logic               w_last;
    logic               w_slot_free;

`ifdef ACT_ROUND_EN
    logic signed [16:0] w_bias;
`endif

    // Requantize the incoming element: widen, optional rounding bias, arithmetic shift, clamp.
    always_comb begin
        w_ext = {in_data[15], in_data};
`ifdef ACT_ROUND_EN
        w_bias = '0;
        if (shift != 4'd0) begin
            w_bias = 17'sd1 <<< (shift - 4'd1);
        end
        w_sum = w_ext + w_bias;
`else
        w_sum = w_ext;
`endif
        w_t = w_sum >>> shift;
        if (w_t > 17'sd127) begin
            w_q = 8'h7F;
        end else if (w_t < -17'sd128) begin
            w_q = 8'h80;
        end else begin
            w_q = w_t[7:0];
        end
    end

    // Fill buffer as it will look with the current element written into its lane.
    always_comb begin
        w_fill_next = r_fill;
        for (int i = 0; i < int'(N); i++) begin
            if (r_fill_count == CW'(i)) begin
                w_fill_next[LW*i +: LW] = w_q;
            end
        end
    end

    assign w_accept    = in_valid & r_in_ready;
    assign w_xfer      = r_vec_valid & vec_ready;
    assign w_last      = w_accept && (r_fill_count == CW'(N - 1));
    assign w_slot_free = !r_vec_valid || vec_ready;

    // r_in_ready is the inverse of the fill-buffer-full flag, kept as its own register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill       <= '0;
            r_fill_count <= '0;
            r_in_ready   <= 1'b1;
            r_vec_data   <= '0;
            r_vec_valid  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fill       <= w_fill_next;
                r_fill_count <= w_last ? '0 : r_fill_count + CW'(1);
            end

            if (w_last && w_slot_free) begin
                r_vec_data  <= w_fill_next;
                r_vec_valid <= 1'b1;
            end else if (w_last) begin
                r_in_ready  <= 1'b0;
            end else if (!r_in_ready && w_xfer) begin
                r_vec_data  <= r_fill;
                r_vec_valid <= 1'b1;
                r_in_ready  <= 1'b1;
            end else if (w_xfer) begin
                r_vec_valid <= 1'b0;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign vec_data   = r_vec_data;
    assign vec_valid  = r_vec_valid;
    assign fill_count = r_fill_count;

endmodule

// File: tb/tb_act_requant_pack.sv
// Bench for act_requant_pack: constant vector table, directed corner sequences and a random run
// scored against a queue-based model of complete/held vectors.
module tb_act_requant_pack;

    localparam int unsigned N  = 16;
    localparam int unsigned CW = 5;
    localparam int unsigned VW = 8 * N;

    logic              clk;
    logic              reset;
    logic [15:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        shift;
    logic [VW-1:0]     vec_data;
    logic              vec_valid;
    logic              vec_ready;
    logic [CW-1:0]     fill_count;

    act_requant_pack #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .shift      (shift),
        .vec_data   (vec_data),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .fill_count (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: completed vectors not yet transferred, lanes of the partial vector, last shown vector.
    logic [VW-1:0] exp_q[$];
    logic [7:0]    part[$];
    logic [VW-1:0] last_data;

    typedef struct {
        logic [15:0] din;
        logic [3:0]  sh;
        logic [7:0]  lane;
    } vec_t;
    vec_t tbl[16];

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requantization from the arithmetic definition: floor division by 2^s, then clamp.
    function automatic logic [7:0] ref_q(input logic [15:0] d, input logic [3:0] s);
        int v, den, t;
        v   = $signed(d);
        den = 1 << s;
`ifdef ACT_ROUND_EN
        if (s != 4'd0) v = v + den / 2;
`endif
        if (v >= 0) t = v / den;
        else        t = -((-v + den - 1) / den);
        if (t > 127)  t = 127;
        if (t < -128) t = -128;
        return t[7:0];
    endfunction

    task automatic cycle(input logic v, input logic [15:0] d, input logic [3:0] s, input logic r);
        bit m_ready, m_valid;
        logic [VW-1:0] pk;
        in_valid  = v;
        in_data   = d;
        shift     = s;
        vec_ready = r;
        @(negedge clk);
        if (chk_en) begin
            check("vec_valid",  {127'd0, vec_valid}, {127'd0, exp_q.size() != 0});
            check("in_ready",   {127'd0, in_ready},  {127'd0, exp_q.size() < 2});
            check("fill_count", VW'(fill_count),     VW'(part.size()));
            check("vec_data",   vec_data, (exp_q.size() != 0) ? exp_q[0] : last_data);
        end
        if (reset) begin
            exp_q.delete();
            part.delete();
            last_data = '0;
        end else begin
            m_ready = exp_q.size() < 2;
            m_valid = exp_q.size() != 0;
            if (m_valid && r) last_data = exp_q.pop_front();
            if (v && m_ready) begin
                part.push_back(ref_q(d, s));
                if (part.size() == N) begin
                    pk = '0;
                    for (int i = 0; i < int'(N); i++) pk[8*i +: 8] = part[i];
                    exp_q.push_back(pk);
                    part.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, 16'd0, 4'd0, 1'b0);
        reset = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'd0, 4'd0, 1'b1);
    endtask

    initial begin
        reset = 1'b0; in_data = '0; in_valid = 1'b0; shift = '0; vec_ready = 1'b0;
        last_data = '0;

        tbl[0]  = '{16'd1000,   4'd2,  8'd127};
        tbl[1]  = '{-16'sd1000, 4'd2,  8'h80};
        tbl[2]  = '{16'd400,    4'd2,  8'd100};
        tbl[4]  = '{16'd32767,  4'd0,  8'd127};
        tbl[5]  = '{16'h8000,   4'd0,  8'h80};
        tbl[8]  = '{16'd5,      4'd2,  8'd1};
        tbl[9]  = '{16'd255,    4'd1,  8'd127};
        tbl[10] = '{-16'sd256,  4'd1,  8'h80};
        tbl[11] = '{16'd254,    4'd1,  8'd127};
        tbl[13] = '{16'd100,    4'd0,  8'd100};
`ifdef ACT_ROUND_EN
        tbl[3]  = '{-16'sd6,    4'd2,  8'hFF};
        tbl[6]  = '{16'd6,      4'd2,  8'd2};
        tbl[7]  = '{-16'sd6,    4'd2,  8'hFF};
        tbl[12] = '{-16'sd255,  4'd1,  8'h81};
        tbl[14] = '{16'hFFFF,   4'd15, 8'd0};
        tbl[15] = '{16'd32767,  4'd15, 8'd1};
`else
        tbl[3]  = '{-16'sd6,    4'd2,  8'hFE};
        tbl[6]  = '{16'd6,      4'd2,  8'd1};
        tbl[7]  = '{-16'sd6,    4'd2,  8'hFE};
        tbl[12] = '{-16'sd255,  4'd1,  8'h80};
        tbl[14] = '{16'hFFFF,   4'd15, 8'hFF};
        tbl[15] = '{16'd32767,  4'd15, 8'd0};
`endif

        @(posedge clk); #1;
        do_reset();
        check("reset_vec_valid", {127'd0, vec_valid}, '0);
        check("reset_in_ready",  {127'd0, in_ready},  {127'd0, 1'b1});

        // Basic pack: 0..15 at shift 0 with vec_ready held high.
        for (int i = 0; i < 16; i++) cycle(1'b1, 16'(i), 4'd0, 1'b1);
        check("basic_valid", {127'd0, vec_valid}, {127'd0, 1'b1});
        for (int i = 0; i < 16; i++) check("basic_lane", VW'(vec_data[8*i +: 8]), VW'(i));
        drain();

        // Table of saturation / rounding vectors packed into one vector.
        for (int i = 0; i < 16; i++) cycle(1'b1, tbl[i].din, tbl[i].sh, 1'b0);
        check("tbl_valid", {127'd0, vec_valid}, {127'd0, 1'b1});
        for (int i = 0; i < 16; i++) check("tbl_lane", VW'(vec_data[8*i +: 8]), VW'(tbl[i].lane));
        drain();

        // Backpressure: 32 elements with downstream stalled, then release.
        for (int k = 0; k < 32; k++) cycle(1'b1, 16'(k), 4'd0, 1'b0);
        check("bp_in_ready_low", {127'd0, in_ready}, '0);
        cycle(1'b1, 16'd99, 4'd0, 1'b0);
        cycle(1'b0, 16'd0, 4'd0, 1'b1);
        check("bp_second_valid", {127'd0, vec_valid}, {127'd0, 1'b1});
        check("bp_in_ready_back", {127'd0, in_ready}, {127'd0, 1'b1});
        for (int i = 0; i < 16; i++) check("bp_second_lane", VW'(vec_data[8*i +: 8]), VW'(16 + i));
        drain();

        // Simultaneous drain of A and completion of B.
        for (int k = 0; k < 31; k++) cycle(1'b1, 16'(k + 40), 4'd0, 1'b0);
        cycle(1'b1, 16'd71, 4'd0, 1'b1);
        check("sim_valid", {127'd0, vec_valid}, {127'd0, 1'b1});
        check("sim_in_ready", {127'd0, in_ready}, {127'd0, 1'b1});
        check("sim_lane15", VW'(vec_data[8*15 +: 8]), VW'(71));
        drain();

        // Reset mid-fill discards the partial vector.
        for (int k = 0; k < 7; k++) cycle(1'b1, 16'd9, 4'd0, 1'b1);
        do_reset();
        check("rst_fill_count", VW'(fill_count), '0);
        check("rst_vec_valid", {127'd0, vec_valid}, '0);
        for (int k = 0; k < 16; k++) cycle(1'b1, 16'd3, 4'd0, 1'b1);
        for (int i = 0; i < 16; i++) check("rst_lane", VW'(vec_data[8*i +: 8]), VW'(3));
        drain();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
